// File: rtl/in_service_control.sv
// -----------------------------------------------------------------------------
// in_service_control
//
// In-service register, rotating priority map and two-pulse interrupt
// acknowledge sequencer for an 8-input interrupt controller.
//
// The first inta pulse latches the winning IR (or 7 if there is no winner,
// which is flagged as spurious), sets its in-service bit and clears its
// request. The second inta pulse presents the latched vector and can
// optionally perform an automatic EOI.
//
// Ports
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   irr           : masked pending requests (informational only here)
//   highest       : one-hot winning IR from the resolver, 0 = none
//   level         : priority level of highest, 0 = most urgent
//   inta          : one-cycle acknowledge pulse
//   eoi_valid     : EOI command strobe
//   eoi_specific  : 1 = clear eoi_ir, 0 = clear the most urgent in-service IR
//   eoi_rotate    : make the cleared IR the lowest priority
//   eoi_ir        : IR for a specific EOI
//   setpri_valid  : set-priority strobe
//   setpri_bottom : IR that becomes the lowest priority
//   aeoi          : auto-EOI on the second inta
//   aeoi_rotate   : rotate on auto-EOI (honoured only with AUTO_ROTATE_EN)
//   priority_map  : level of IRk at bits [3k+2:3k], feeds the resolver
//                   ("priority" itself is a reserved word)
//   isr           : in-service register
//   int_out       : interrupt request to the CPU
//   irr_clear     : one-cycle pulse clearing the acknowledged request
//   vector_valid  : one-cycle pulse on the second inta
//   vector_ir     : IR number of the vector being delivered
//   spurious      : one-cycle pulse when the first inta finds no winner
//
// Build option
//   AUTO_ROTATE_EN : when defined, an auto-EOI with aeoi_rotate = 1 makes the
//                    acknowledged IR the lowest priority.
// -----------------------------------------------------------------------------
module in_service_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  irr,
    input  logic [7:0]  highest,
    input  logic [2:0]  level,
    input  logic        inta,
    input  logic        eoi_valid,
    input  logic        eoi_specific,
    input  logic        eoi_rotate,
    input  logic [2:0]  eoi_ir,
    input  logic        setpri_valid,
    input  logic [2:0]  setpri_bottom,
    input  logic        aeoi,
    input  logic        aeoi_rotate,
    output logic [23:0] priority_map,
    output logic [7:0]  isr,
    output logic        int_out,
    output logic [7:0]  irr_clear,
    output logic        vector_valid,
    output logic [2:0]  vector_ir,
    output logic        spurious
);

    typedef enum logic {IDLE, ACK2} state_t;

    // IR0..IR7 at levels 0..7, i.e. bottom = 7
    localparam logic [23:0] PRIORITY_RESET =
        {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    state_t      state_reg, state_next;
    logic [2:0]  b_reg, b_next;
    logic [7:0]  isr_reg, isr_next;
    logic [2:0]  vector_ir_reg, vector_ir_next;
    logic        spur_cycle_reg, spur_cycle_next;
    logic [7:0]  irr_clear_reg, irr_clear_next;
    logic        vector_valid_reg, vector_valid_next;
    logic        spurious_reg, spurious_next;
    logic [23:0] priority_reg, priority_next;

    logic [2:0]  ir_level [8];
    logic [3:0]  isr_level;
    logic [2:0]  min_ir;
    logic [2:0]  highest_ir;
    logic [7:0]  clear_bits;
    logic [7:0]  set_bits;
    logic        eoi_rot;
    logic [2:0]  eoi_rot_ir;
    logic        auto_rot;
    logic        auto_rot_en;

    // The request vector is resolved upstream; only highest is acted on here.
    logic unused_irr;
    assign unused_irr = ^irr;

`ifdef AUTO_ROTATE_EN
    assign auto_rot_en = aeoi_rotate;
`else
    // Port kept so both builds share one interface.
    logic unused_aeoi_rotate;
    assign unused_aeoi_rotate = aeoi_rotate;
    assign auto_rot_en = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_level
            assign ir_level[gi] = priority_reg[3*gi +: 3];
        end
    endgenerate

    // Most urgent in-service level (8 = nothing in service) and its IR.
    // Levels form a permutation, so the minimum is unique.
    always_comb begin
        isr_level = 4'd8;
        min_ir    = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (isr_reg[k] && ({1'b0, ir_level[k]} < isr_level)) begin
                isr_level = {1'b0, ir_level[k]};
                min_ir    = 3'(k);
            end
        end
    end

    always_comb begin
        highest_ir = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (highest[k]) begin
                highest_ir = 3'(k);
            end
        end
    end

    assign int_out = (state_reg == IDLE) && (highest != 8'd0) &&
                     ({1'b0, level} < isr_level);

    always_comb begin
        state_next        = state_reg;
        b_next            = b_reg;
        vector_ir_next    = vector_ir_reg;
        spur_cycle_next   = spur_cycle_reg;
        irr_clear_next    = 8'd0;
        vector_valid_next = 1'b0;
        spurious_next     = 1'b0;
        clear_bits        = 8'd0;
        set_bits          = 8'd0;
        eoi_rot           = 1'b0;
        eoi_rot_ir        = eoi_ir;
        auto_rot          = 1'b0;

        if (eoi_valid) begin
            if (eoi_specific) begin
                clear_bits[eoi_ir] = 1'b1;
                eoi_rot            = eoi_rotate;
                eoi_rot_ir         = eoi_ir;
            end else if (isr_reg != 8'd0) begin
                clear_bits[min_ir] = 1'b1;
                eoi_rot            = eoi_rotate;
                eoi_rot_ir         = min_ir;
            end
        end

        case (state_reg)
            IDLE: begin
                if (inta) begin
                    if (highest != 8'd0) begin
                        set_bits[highest_ir] = 1'b1;
                        irr_clear_next       = set_bits;
                        vector_ir_next       = highest_ir;
                        spur_cycle_next      = 1'b0;
                    end else begin
                        vector_ir_next  = 3'd7;
                        spurious_next   = 1'b1;
                        spur_cycle_next = 1'b1;
                    end
                    state_next = ACK2;
                end
            end
            ACK2: begin
                // highest is deliberately not looked at here: the vector was
                // frozen on the first pulse.
                if (inta) begin
                    vector_valid_next = 1'b1;
                    if (aeoi && !spur_cycle_reg) begin
                        clear_bits[vector_ir_reg] = 1'b1;
                        auto_rot                  = auto_rot_en;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // A set from inta overrides a clear of the same bit in the same cycle.
        isr_next = (isr_reg & ~clear_bits) | set_bits;

        if (eoi_rot) begin
            b_next = eoi_rot_ir;
        end else if (auto_rot) begin
            b_next = vector_ir_reg;
        end else if (setpri_valid) begin
            b_next = setpri_bottom;
        end

        // Built from b_next so the map follows a rotation on the same edge.
        for (int k = 0; k < 8; k++) begin
            priority_next[3*k +: 3] = 3'(k) - b_next - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            b_reg            <= 3'd7;
            isr_reg          <= 8'd0;
            vector_ir_reg    <= 3'd0;
            spur_cycle_reg   <= 1'b0;
            irr_clear_reg    <= 8'd0;
            vector_valid_reg <= 1'b0;
            spurious_reg     <= 1'b0;
            priority_reg     <= PRIORITY_RESET;
        end else begin
            state_reg        <= state_next;
            b_reg            <= b_next;
            isr_reg          <= isr_next;
            vector_ir_reg    <= vector_ir_next;
            spur_cycle_reg   <= spur_cycle_next;
            irr_clear_reg    <= irr_clear_next;
            vector_valid_reg <= vector_valid_next;
            spurious_reg     <= spurious_next;
            priority_reg     <= priority_next;
        end
    end

    assign priority_map = priority_reg;
    assign isr          = isr_reg;
    assign irr_clear    = irr_clear_reg;
    assign vector_valid = vector_valid_reg;
    assign vector_ir    = vector_ir_reg;
    assign spurious     = spurious_reg;

endmodule

// File: tb/tb_in_service_control.sv
module tb_in_service_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irr;
    logic [7:0]  highest;
    logic [2:0]  level;
    logic        inta;
    logic        eoi_valid;
    logic        eoi_specific;
    logic        eoi_rotate;
    logic [2:0]  eoi_ir;
    logic        setpri_valid;
    logic [2:0]  setpri_bottom;
    logic        aeoi;
    logic        aeoi_rotate;
    logic [23:0] priority_map;
    logic [7:0]  isr;
    logic        int_out;
    logic [7:0]  irr_clear;
    logic        vector_valid;
    logic [2:0]  vector_ir;
    logic        spurious;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [2:0] m_b;
    logic [7:0] m_isr;
    bit         m_ack2;
    bit         m_spur;
    logic [2:0] m_vir;
    logic [7:0] m_irc;
    bit         m_vv;
    bit         m_sp;

    always #5 clk = ~clk;

    in_service_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irr           (irr),
        .highest       (highest),
        .level         (level),
        .inta          (inta),
        .eoi_valid     (eoi_valid),
        .eoi_specific  (eoi_specific),
        .eoi_rotate    (eoi_rotate),
        .eoi_ir        (eoi_ir),
        .setpri_valid  (setpri_valid),
        .setpri_bottom (setpri_bottom),
        .aeoi          (aeoi),
        .aeoi_rotate   (aeoi_rotate),
        .priority_map  (priority_map),
        .isr           (isr),
        .int_out       (int_out),
        .irr_clear     (irr_clear),
        .vector_valid  (vector_valid),
        .vector_ir     (vector_ir),
        .spurious      (spurious)
    );

    // Level of IRk with bottom b: (k - b - 1) mod 8
    function automatic logic [2:0] lvl_of(int k, logic [2:0] b);
        return 3'((k - int'(b) - 1) & 7);
    endfunction

    function automatic logic [23:0] map_of(logic [2:0] b);
        logic [23:0] r;
        for (int k = 0; k < 8; k++) r[3*k +: 3] = lvl_of(k, b);
        return r;
    endfunction

    function automatic int isr_lvl(logic [7:0] s, logic [2:0] b);
        int best = 8;
        for (int k = 0; k < 8; k++)
            if (s[k] && int'(lvl_of(k, b)) < best) best = int'(lvl_of(k, b));
        return best;
    endfunction

    task automatic set_idle();
        irr = 8'd0; highest = 8'd0; level = 3'd0; inta = 1'b0;
        eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_ir = 3'd0;
        setpri_valid = 1'b0; setpri_bottom = 3'd0; aeoi = 1'b0; aeoi_rotate = 1'b0;
    endtask

    task automatic model_reset();
        m_b = 3'd7; m_isr = 8'd0; m_ack2 = 0; m_spur = 0; m_vir = 3'd0;
        m_irc = 8'd0; m_vv = 0; m_sp = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [7:0] n_isr;
        logic [2:0] n_b;
        logic [2:0] rot_ir;
        bit         eoi_rot, auto_rot;
        int         best, bestl, win;
        n_isr = m_isr; n_b = m_b; rot_ir = 3'd0; eoi_rot = 0; auto_rot = 0;
        m_irc = 8'd0; m_vv = 0; m_sp = 0;
        if (eoi_valid) begin
            if (eoi_specific) begin
                n_isr[eoi_ir] = 1'b0; eoi_rot = eoi_rotate; rot_ir = eoi_ir;
            end else if (m_isr != 8'd0) begin
                best = 0; bestl = 8;
                for (int k = 0; k < 8; k++)
                    if (m_isr[k] && int'(lvl_of(k, m_b)) < bestl) begin
                        best = k; bestl = int'(lvl_of(k, m_b));
                    end
                n_isr[best] = 1'b0; eoi_rot = eoi_rotate; rot_ir = 3'(best);
            end
        end
        if (inta) begin
            if (m_ack2) begin
                m_vv = 1;
                if (aeoi && !m_spur) begin
                    n_isr[m_vir] = 1'b0;
`ifdef AUTO_ROTATE_EN
                    auto_rot = aeoi_rotate;
`endif
                end
                m_ack2 = 0;
            end else if (highest != 8'd0) begin
                win = 0;
                for (int k = 0; k < 8; k++) if (highest[k]) win = k;
                n_isr[win] = 1'b1;
                m_irc = highest; m_vir = 3'(win); m_spur = 0; m_ack2 = 1;
            end else begin
                m_vir = 3'd7; m_sp = 1; m_spur = 1; m_ack2 = 1;
            end
        end
        if (eoi_rot) n_b = rot_ir;
        else if (auto_rot) n_b = m_vir;
        else if (setpri_valid) n_b = setpri_bottom;
        m_isr = n_isr; m_b = n_b;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [23:0] exp_map;
        for (int k = 0; k < 8; k++) exp_map[3*k +: 3] = 3'(k);
        set_idle();
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (isr !== 8'd0) begin errors++; $display("FAIL reset_isr: got %h want 00", isr); end
        checks++; if (priority_map !== exp_map) begin errors++; $display("FAIL reset_priority: got %h want %h", priority_map, exp_map); end
        checks++; if (vector_ir !== 3'd0) begin errors++; $display("FAIL reset_vector_ir: got %0d want 0", vector_ir); end
        checks++; if ({irr_clear, vector_valid, spurious} !== 10'd0) begin errors++; $display("FAIL reset_pulses: got %h/%b/%b want 0", irr_clear, vector_valid, spurious); end
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL reset_int_out: got %b want 0", int_out); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        $display("reset: isr=%h priority=%h", isr, priority_map);
    endtask

    task automatic test_ack_sequence();
        highest = 8'h04; level = 3'd2; inta = 1'b1;
        step();
        inta = 1'b0;
        checks++; if (irr_clear !== 8'h04) begin errors++; $display("FAIL ack1_irr_clear: got %h want 04", irr_clear); end
        checks++; if (isr !== 8'h04) begin errors++; $display("FAIL ack1_isr: got %h want 04", isr); end
        checks++; if (vector_valid !== 1'b0 || spurious !== 1'b0) begin errors++; $display("FAIL ack1_pulses: got vv=%b sp=%b want 0/0", vector_valid, spurious); end
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL ack2_state_int_out: got %b want 0", int_out); end
        step();
        checks++; if (irr_clear !== 8'h00) begin errors++; $display("FAIL irr_clear_pulse: got %h want 00", irr_clear); end
        inta = 1'b1;
        step();
        inta = 1'b0;
        checks++; if (vector_valid !== 1'b1 || vector_ir !== 3'd2) begin errors++; $display("FAIL ack2_vector: got vv=%b ir=%0d want 1/2", vector_valid, vector_ir); end
        #1;
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL int_out_equal_level: got %b want 0", int_out); end
        $display("ack IR2: isr=%h vector_ir=%0d", isr, vector_ir);
    endtask

    task automatic test_int_out();
        highest = 8'h01; level = 3'd0;
        #1;
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL int_out_higher: got %b want 1", int_out); end
        highest = 8'h10; level = 3'd4;
        #1;
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL int_out_lower: got %b want 0", int_out); end
        $display("int_out: isr=%h", isr);
    endtask

    task automatic test_eoi_rotate();
        highest = 8'h10; level = 3'd4; inta = 1'b1;
        step();
        inta = 1'b0;
        step();
        inta = 1'b1;
        step();
        inta = 1'b0; highest = 8'h00; level = 3'd0;
        checks++; if (isr !== 8'h14) begin errors++; $display("FAIL eoi_setup_isr: got %h want 14", isr); end
        eoi_valid = 1'b1; eoi_specific = 1'b0; eoi_rotate = 1'b1;
        step();
        eoi_valid = 1'b0; eoi_rotate = 1'b0;
        checks++; if (isr !== 8'h10) begin errors++; $display("FAIL nseoi_isr: got %h want 10", isr); end
        checks++; if (priority_map[11:9] !== 3'd0 || priority_map[8:6] !== 3'd7) begin errors++; $display("FAIL nseoi_rotate: got ir3=%0d ir2=%0d want 0/7", priority_map[11:9], priority_map[8:6]); end
        $display("eoi rotate: isr=%h priority=%h", isr, priority_map);
    endtask

    task automatic test_spurious();
        highest = 8'h00; inta = 1'b1;
        step();
        inta = 1'b0;
        checks++; if (spurious !== 1'b1 || irr_clear !== 8'h00) begin errors++; $display("FAIL spurious_pulse: got sp=%b irc=%h want 1/00", spurious, irr_clear); end
        checks++; if (isr !== 8'h10) begin errors++; $display("FAIL spurious_isr: got %h want 10", isr); end
        step();
        checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL spurious_one_cycle: got %b want 0", spurious); end
        highest = 8'h02; inta = 1'b1;
        step();
        inta = 1'b0;
        checks++; if (vector_valid !== 1'b1 || vector_ir !== 3'd7 || isr !== 8'h10) begin errors++; $display("FAIL spurious_vector: got vv=%b ir=%0d isr=%h want 1/7/10", vector_valid, vector_ir, isr); end
        highest = 8'h00;
        $display("spurious: vector_ir=%0d isr=%h", vector_ir, isr);
    endtask

    task automatic test_collision();
        // same bit: inta set beats specific EOI; EOI rotate beats set-priority
        highest = 8'h10; inta = 1'b1;
        eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_ir = 3'd4; eoi_rotate = 1'b1;
        setpri_valid = 1'b1; setpri_bottom = 3'd1;
        step();
        set_idle();
        checks++; if (isr !== 8'h10) begin errors++; $display("FAIL same_bit_set_wins: got %h want 10", isr); end
        checks++; if (priority_map[17:15] !== 3'd0) begin errors++; $display("FAIL rotate_over_setpri: got ir5=%0d want 0", priority_map[17:15]); end
        inta = 1'b1;
        step();
        // different bits: both applied
        highest = 8'h01; inta = 1'b1;
        eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_ir = 3'd4;
        step();
        set_idle();
        checks++; if (isr !== 8'h01) begin errors++; $display("FAIL diff_bits_both: got %h want 01", isr); end
        inta = 1'b1;
        step();
        set_idle();
        setpri_valid = 1'b1; setpri_bottom = 3'd3;
        step();
        setpri_valid = 1'b0;
        checks++; if (priority_map[14:12] !== 3'd0 || isr !== 8'h01) begin errors++; $display("FAIL setpri: got ir4=%0d isr=%h want 0/01", priority_map[14:12], isr); end
        $display("collision: isr=%h priority=%h", isr, priority_map);
    endtask

    task automatic test_aeoi();
        logic [2:0] exp_ir5;
`ifdef AUTO_ROTATE_EN
        exp_ir5 = 3'd7;
`else
        exp_ir5 = 3'd5;
`endif
        do_reset();
        aeoi = 1'b1; aeoi_rotate = 1'b1;
        highest = 8'h20; level = 3'd5; inta = 1'b1;
        step();
        inta = 1'b0;
        checks++; if (isr !== 8'h20) begin errors++; $display("FAIL aeoi_set: got %h want 20", isr); end
        step();
        inta = 1'b1;
        step();
        inta = 1'b0;
        checks++; if (isr !== 8'h00 || vector_valid !== 1'b1 || vector_ir !== 3'd5) begin errors++; $display("FAIL aeoi_clear: got isr=%h vv=%b ir=%0d want 00/1/5", isr, vector_valid, vector_ir); end
        checks++; if (priority_map[17:15] !== exp_ir5) begin errors++; $display("FAIL aeoi_rotate: got ir5=%0d want %0d", priority_map[17:15], exp_ir5); end
        set_idle();
        $display("aeoi: isr=%h priority=%h", isr, priority_map);
    endtask

    task automatic test_reset_mid_ack();
        do_reset();
        highest = 8'h02; level = 3'd1; inta = 1'b1;
        step();
        inta = 1'b0;
        checks++; if (isr !== 8'h02) begin errors++; $display("FAIL midack_setup: got %h want 02", isr); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (isr !== 8'h00 || vector_ir !== 3'd0) begin errors++; $display("FAIL midack_async: got isr=%h ir=%0d want 00/0", isr, vector_ir); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        highest = 8'h08; level = 3'd3; inta = 1'b1;
        step();
        inta = 1'b0;
        checks++; if (vector_valid !== 1'b0 || irr_clear !== 8'h08 || isr !== 8'h08) begin errors++; $display("FAIL midack_first: got vv=%b irc=%h isr=%h want 0/08/08", vector_valid, irr_clear, isr); end
        step();
        inta = 1'b1;
        step();
        inta = 1'b0;
        checks++; if (vector_valid !== 1'b1 || vector_ir !== 3'd3) begin errors++; $display("FAIL midack_second: got vv=%b ir=%0d want 1/3", vector_valid, vector_ir); end
        set_idle();
        $display("reset mid-ack: vector_ir=%0d isr=%h", vector_ir, isr);
    endtask

    task automatic test_random();
        int win, wl;
        logic [23:0] exp_map;
        bit exp_int;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            irr = 8'($urandom);
            if ($urandom_range(7) == 0) irr = 8'd0;
            win = -1; wl = 8;
            for (int k = 0; k < 8; k++)
                if (irr[k] && int'(lvl_of(k, m_b)) < wl) begin win = k; wl = int'(lvl_of(k, m_b)); end
            highest = (win < 0) ? 8'd0 : 8'(1 << win);
            level = (win < 0) ? 3'd0 : 3'(wl);
            inta = ($urandom_range(2) == 0);
            eoi_valid = ($urandom_range(5) == 0);
            eoi_specific = 1'($urandom);
            eoi_rotate = 1'($urandom);
            eoi_ir = 3'($urandom);
            setpri_valid = ($urandom_range(9) == 0);
            setpri_bottom = 3'($urandom);
            aeoi = 1'($urandom);
            aeoi_rotate = 1'($urandom);
            #1;
            exp_int = !m_ack2 && (highest != 8'd0) && (int'(level) < isr_lvl(m_isr, m_b));
            checks++; if (int_out !== exp_int) begin errors++; $display("FAIL rnd_int_out[%0d]: got %b want %b", n, int_out, exp_int); end
            step();
            exp_map = map_of(m_b);
            checks++; if (isr !== m_isr) begin errors++; $display("FAIL rnd_isr[%0d]: got %h want %h", n, isr, m_isr); end
            checks++; if (priority_map !== exp_map) begin errors++; $display("FAIL rnd_priority[%0d]: got %h want %h", n, priority_map, exp_map); end
            checks++; if (vector_ir !== m_vir) begin errors++; $display("FAIL rnd_vector_ir[%0d]: got %0d want %0d", n, vector_ir, m_vir); end
            checks++; if ({irr_clear, vector_valid, spurious} !== {m_irc, m_vv, m_sp}) begin errors++; $display("FAIL rnd_pulses[%0d]: got %h/%b/%b want %h/%b/%b", n, irr_clear, vector_valid, spurious, m_irc, m_vv, m_sp); end
            if (m_vv || m_irc != 8'd0 || m_sp)
                $display("rnd %0d: isr=%h vector_ir=%0d vv=%b irc=%h sp=%b", n, isr, vector_ir, vector_valid, irr_clear, spurious);
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_ack_sequence();
        test_int_out();
        test_eoi_rotate();
        test_spurious();
        test_collision();
        test_aeoi();
        test_reset_mid_ack();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
